ks_add_scheduler: RTL and testbench

KS_ADD_SCHEDULER -- requirements
Module: ks_add_scheduler

---
 rtl/ks_add_scheduler_pkg.sv | 16 +
 rtl/ks_add_scheduler_if.sv | 41 ++++
 rtl/ks_add_scheduler_slice.sv | 43 ++++
 rtl/ks_add_scheduler.sv | 123 ++++++++++++
 tb/tb_ks_add_scheduler.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ks_add_scheduler_pkg.sv
// rtl/ks_add_scheduler_pkg.sv - shared types and slice-count helper for the adder scheduler
package ks_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/ks_add_scheduler_if.sv
// rtl/ks_add_scheduler_if.sv - requester, result and status signals of the adder scheduler
interface ks_add_scheduler_if #(
  parameter int WIDTH = 16
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_id;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_id, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_id, busy
  );

endinterface

// File: rtl/ks_add_scheduler_slice.sv
// rtl/ks_add_scheduler_slice.sv - combinational SLICE-bit Kogge-Stone adder with carry in/out
module ks_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE-1:0] px;
  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] gn;
  logic [SLICE-1:0] pn;
  logic [SLICE:0]   c;

  assign px = a ^ b;

  // Prefix tree: after the level with span d, g[i]/p[i] cover bits max(0,i-2d+1)..i.
  always_comb begin
    g  = a & b;
    p  = px;
    gn = g;
    pn = p;
    for (int d = 1; d < SLICE; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < SLICE; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
  end

  assign c    = {g | (p & {SLICE{cin}}), cin};
  assign sum  = px ^ c[SLICE-1:0];
  assign cout = c[SLICE];

endmodule

// File: rtl/ks_add_scheduler.sv
// rtl/ks_add_scheduler.sv - round-robin two-requester adder that walks operands through one shared slice
module ks_add_scheduler
  import ks_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic          clk,
  input logic          rst,
  ks_add_scheduler_if.slave bus
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t           state;
  state_t           state_next;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  req_id_t          id_q;
  req_id_t          last_q;
  req_id_t          grant;
  logic             any_valid;
  logic             accept;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;

  assign any_valid = bus.req0_valid | bus.req1_valid;

  // On a tie, serve whoever was not granted last.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && any_valid) begin
          accept         = 1'b1;
          bus.req0_ready = (grant == 1'b0);
          bus.req1_ready = (grant == 1'b1);
          state_next     = RUN;
        end
      end
      RUN: begin
        if (k == K_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign slice_a = a_q[k*SLICE +: SLICE];
  assign slice_b = b_q[k*SLICE +: SLICE];

  ks_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q     <= grant ? bus.req1_a : bus.req0_a;
        b_q     <= grant ? bus.req1_b : bus.req0_b;
        carry_q <= grant ? bus.req1_cin : bus.req0_cin;
        id_q    <= grant;
        last_q  <= grant;
        k       <= '0;
      end else if (state == RUN) begin
        sum_q[k*SLICE +: SLICE] <= slice_sum;
        carry_q                 <= slice_cout;
        cout_q                  <= slice_cout;
        k                       <= k + 1'b1;
      end
    end
  end

  assign bus.res_valid = (state == DONE);
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_id    = id_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_ks_add_scheduler.sv
// tb/tb_ks_add_scheduler.sv - self-checking bench for ks_add_scheduler with a transaction-level model
module tb_ks_add_scheduler;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ks_add_scheduler_if #(.WIDTH(WIDTH)) bus ();

  ks_add_scheduler #(
    .WIDTH(WIDTH),
    .SLICE(SLICE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic             id;
    logic             cout;
    logic [WIDTH-1:0] sum;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   valid_cycles = 0;
  res_t log_q[$];

  // Model: an accepted op occupies the unit for NSLICE cycles, then waits for res_ready.
  bit               m_busy = 1'b0;
  bit               m_done = 1'b0;
  bit               m_last = 1'b1;
  bit               m_zero = 1'b1;
  int               m_cnt  = 0;
  logic [WIDTH-1:0] m_sum  = '0;
  bit               m_cout = 1'b0;
  bit               m_id   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : compare
    logic             g;
    logic             anyv;
    logic [WIDTH:0]   t;
    @(posedge clk);
    forever begin
      @(negedge clk);
      anyv = bus.req0_valid | bus.req1_valid;
      g    = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      check("req0_ready", bus.req0_ready, !rst && !m_busy && anyv && !g);
      check("req1_ready", bus.req1_ready, !rst && !m_busy && anyv && g);
      check("res_valid", bus.res_valid, m_done);
      check("busy", bus.busy, m_busy);
      if (m_done) begin
        check("res_sum", bus.res_sum, m_sum);
        check("res_cout", bus.res_cout, m_cout);
        check("res_id", bus.res_id, m_id);
      end else if (m_zero) begin
        check("reset_sum", bus.res_sum, 0);
        check("reset_cout", bus.res_cout, 0);
        check("reset_id", bus.res_id, 0);
      end
      if (bus.res_valid) valid_cycles++;
      if (bus.res_valid && bus.res_ready && !rst) log_q.push_back({bus.res_id, bus.res_cout, bus.res_sum});

      if (rst) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_last = 1'b1;
        m_zero = 1'b1;
      end else if (!m_busy) begin
        if (anyv) begin
          if (g) t = {1'b0, bus.req1_a} + {1'b0, bus.req1_b} + (WIDTH+1)'(bus.req1_cin);
          else   t = {1'b0, bus.req0_a} + {1'b0, bus.req0_b} + (WIDTH+1)'(bus.req0_cin);
          m_sum  = t[WIDTH-1:0];
          m_cout = t[WIDTH];
          m_id   = g;
          m_last = g;
          m_busy = 1'b1;
          m_cnt  = NSLICE;
          m_zero = 1'b0;
        end
      end else if (!m_done) begin
        m_cnt--;
        if (m_cnt == 0) m_done = 1'b1;
      end else if (bus.res_ready) begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit id, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? bus.req1_ready : bus.req0_ready;
      tick();
    end
  endtask

  task automatic run_op(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit cin, input logic [WIDTH-1:0] exp_sum, input bit exp_cout,
                        input int hold);
    bit got;
    int lat;
    bus.res_ready = 1'b0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
    end
    wait_ready(id, got);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("accept", got, 1);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.res_valid;
      if (!got) begin
        tick();
        lat++;
      end
    end
    check("latency", lat, 4);
    check("lit_sum", bus.res_sum, exp_sum);
    check("lit_cout", bus.res_cout, exp_cout);
    check("lit_id", bus.res_id, id);
    tick();
    if (hold > 1) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
    end
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.res_valid, 1);
      check("hold_sum", bus.res_sum, exp_sum);
      check("hold_ready", {bus.req0_ready, bus.req1_ready}, 0);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("released", bus.res_valid, 0);
    tick();
  endtask

  initial begin : stimulus
    bit got;
    bit r0;
    bit r1;
    bit both_seen;
    int vc;
    int n0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
    bus.res_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sum", bus.res_sum, 0);
    check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
    tick();

    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1);
    run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1);
    run_op(1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 3);

    // Reset in the second RUN cycle must drop the operation.
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0F0F; bus.req0_b = 16'h00F1; bus.req0_cin = 1'b0;
    wait_ready(1'b0, got);
    bus.req0_valid = 1'b0;
    check("rst_op_accept", got, 1);
    tick();
    vc  = valid_cycles;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("rst_no_result", valid_cycles - vc, 0);
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1);

    // Tie on the first cycle after reset: req0 first, then req1.
    rst = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0003; bus.req0_b = 16'h0004; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0010; bus.req1_b = 16'h0020; bus.req1_cin = 1'b1;
    n0 = log_q.size();
    both_seen = 1'b0;
    for (int i = 0; i < 40 && (bus.req0_valid || bus.req1_valid || bus.busy); i++) begin
      @(negedge clk);
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      if (r0 && r1) both_seen = 1'b1;
      tick();
      if (r0) bus.req0_valid = 1'b0;
      if (r1) bus.req1_valid = 1'b0;
    end
    bus.res_ready = 1'b0;
    check("tie_both_ready", both_seen, 0);
    check("tie_count", log_q.size() - n0, 2);
    if (log_q.size() - n0 == 2) begin
      check("tie_first_id", log_q[n0].id, 0);
      check("tie_first_sum", log_q[n0].sum, 16'h0007);
      check("tie_second_id", log_q[n0+1].id, 1);
      check("tie_second_sum", log_q[n0+1].sum, 16'h0031);
    end

    for (int c = 0; c < 500; c++) begin
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req1_valid = 1'($urandom_range(0, 1));
      bus.req0_a     = 16'($urandom);
      bus.req1_a     = 16'($urandom);
      bus.req0_b     = ($urandom_range(0, 3) == 0) ? ~bus.req0_a : 16'($urandom);
      bus.req1_b     = ($urandom_range(0, 3) == 0) ? ~bus.req1_a : 16'($urandom);
      bus.req0_cin   = 1'($urandom_range(0, 1));
      bus.req1_cin   = 1'($urandom_range(0, 1));
      bus.res_ready  = ($urandom_range(0, 3) != 0);
      rst            = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("drain_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
